// File: rtl/booth_spm_divider.sv
// Sequential signed divider: switch/Go operand entry, restoring shift-subtract on
// magnitudes (one quotient bit per clock). Optional Ovf port under DIV_OVF_DETECT_EN.
module booth_spm_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   SW,
    input  logic               Go,
    output logic [2*WIDTH-1:0] Answer,
    output logic               Over,
    output logic               Div_Zero
`ifdef DIV_OVF_DETECT_EN
    ,
    output logic               Ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        INIT,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t           state_reg;
    logic             go_q_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt_reg;

    logic             go_rise;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_sub;
    logic             fits;
    logic [WIDTH-1:0] q_val;
    logic [WIDTH-1:0] rem_val;
    logic             ovf_case;

    assign go_rise = Go & ~go_q_reg;

    // Magnitudes as W-bit unsigned: |-2^(W-1)| keeps its bit pattern 2^(W-1).
    assign mag_a = a_reg[WIDTH-1] ? (~a_reg + 1'b1) : a_reg;
    assign mag_b = b_reg[WIDTH-1] ? (~b_reg + 1'b1) : b_reg;

    assign r_shift = {r_reg, m_reg[WIDTH-1]};
    assign r_sub   = r_shift - {1'b0, d_reg};
    assign fits    = (r_shift >= {1'b0, d_reg});

    assign q_val    = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) ? (~m_reg + 1'b1) : m_reg;
    assign rem_val  = a_reg[WIDTH-1] ? (~r_reg + 1'b1) : r_reg;
    assign ovf_case = (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (b_reg == {WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= GET_A;
            go_q_reg  <= 1'b1;
            a_reg     <= '0;
            b_reg     <= '0;
            m_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            Answer    <= '0;
            Over      <= 1'b0;
            Div_Zero  <= 1'b0;
`ifdef DIV_OVF_DETECT_EN
            Ovf       <= 1'b0;
`endif
        end else begin
            go_q_reg <= Go;
            case (state_reg)
                GET_A: begin
                    if (go_rise) begin
                        a_reg     <= SW;
                        Over      <= 1'b0;
                        Div_Zero  <= 1'b0;
`ifdef DIV_OVF_DETECT_EN
                        Ovf       <= 1'b0;
`endif
                        state_reg <= GET_B;
                    end
                end
                GET_B: begin
                    if (go_rise) begin
                        b_reg     <= SW;
                        state_reg <= INIT;
                    end
                end
                INIT: begin
                    m_reg   <= mag_a;
                    d_reg   <= mag_b;
                    r_reg   <= '0;
                    cnt_reg <= '0;
                    if (b_reg == '0) begin
                        Answer    <= {a_reg, {WIDTH{1'b1}}};
                        Div_Zero  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= ITER;
                    end
                end
                ITER: begin
                    r_reg   <= fits ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
                    m_reg   <= {m_reg[WIDTH-2:0], fits};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    Answer    <= {rem_val, q_val};
                    Over      <= 1'b1;
`ifdef DIV_OVF_DETECT_EN
                    Ovf       <= ovf_case;
`endif
                    state_reg <= DONE;
                end
                DONE: begin
                    // A new Go edge starts the next operation directly with A.
                    if (go_rise) begin
                        a_reg     <= SW;
                        Over      <= 1'b0;
                        Div_Zero  <= 1'b0;
`ifdef DIV_OVF_DETECT_EN
                        Ovf       <= 1'b0;
`endif
                        state_reg <= GET_B;
                    end else begin
                        Over <= 1'b1;
                    end
                end
                default: state_reg <= GET_A;
            endcase
        end
    end

`ifndef DIV_OVF_DETECT_EN
    logic unused_ovf;
    assign unused_ovf = ovf_case;
`endif

endmodule
